// File: rtl/mram_wbuf.sv
// Write-posting buffer in front of the SPI MRAM controller: writes are acked at once and drained
// in order; reads go downstream only once every posted write has completed.
module mram_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [29:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        mStb_o,
  output logic        mWe_o,
  output logic [3:0]  mSel_o,
  output logic [29:0] mAdr_o,
  output logic [31:0] mDat_o,
  input  logic [31:0] mDat_i,
  input  logic        mAck_i,
  output logic        empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t        state_q, state_d;
  logic [65:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          mstb_q, mstb_d;
  logic          mwe_q, mwe_d;
  logic [3:0]    msel_q, msel_d;
  logic [29:0]   madr_q, madr_d;
  logic [31:0]   mdat_q, mdat_d;
  logic          empty_q, empty_d;

  logic req, full, push, pop, wr_ack, rd_pend;

  // A held strobe is never looked at while ack_o is high, so one request is taken once.
  assign req     = stb_i && !ack_q;
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign push    = req && we_i && (sel_i != 4'b0000) && !full;
  assign wr_ack  = req && we_i && ((sel_i == 4'b0000) || !full);
  assign rd_pend = req && !we_i;
  assign pop     = (state_q == S_WRITE) && mAck_i;

  always_comb begin
    state_d = state_q;
    ack_d   = wr_ack;
    dat_d   = dat_q;
    mstb_d  = mstb_q;
    mwe_d   = mwe_q;
    msel_d  = msel_q;
    madr_d  = madr_q;
    mdat_d  = mdat_q;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          state_d = S_WRITE;
          mstb_d  = 1'b1;
          mwe_d   = 1'b1;
          {madr_d, msel_d, mdat_d} = mem_q[rd_ptr_q];
        end else if (rd_pend) begin
          state_d = S_READ;
          mstb_d  = 1'b1;
          mwe_d   = 1'b0;
          madr_d  = adr_i;
          msel_d  = sel_i;
        end
      end
      S_WRITE: begin
        if (mAck_i) begin
          state_d = S_IDLE;
          mstb_d  = 1'b0;
        end
      end
      S_READ: begin
        if (mAck_i) begin
          state_d = S_IDLE;
          mstb_d  = 1'b0;
          dat_d   = mDat_i;
          ack_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign empty_d = (cnt_d == '0);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {adr_i, sel_i, dat_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      mstb_q   <= 1'b0;
      mwe_q    <= 1'b0;
      msel_q   <= '0;
      madr_q   <= '0;
      mdat_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      mstb_q   <= mstb_d;
      mwe_q    <= mwe_d;
      msel_q   <= msel_d;
      madr_q   <= madr_d;
      mdat_q   <= mdat_d;
      empty_q  <= empty_d;
    end
  end

  assign dat_o   = dat_q;
  assign ack_o   = ack_q;
  assign mStb_o  = mstb_q;
  assign mWe_o   = mwe_q;
  assign mSel_o  = msel_q;
  assign mAdr_o  = madr_q;
  assign mDat_o  = mdat_q;
  assign empty_o = empty_q;

endmodule

// File: doc/mram_wbuf.md
# mram_wbuf

Write-posting buffer between the CPU data bus and the SPI MRAM controller (`mram`). Accepts bus writes into a FIFO and acknowledges them immediately, then drains them to `mram` in order, hiding the multi-microsecond SPI write time from the CPU. Reads are forwarded to `mram` only after all posted writes have drained, which guarantees read-after-write ordering. Upstream port faces the CPU; downstream port connects 1:1 to the `mram` bus port.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk_i` in 1: system clock, all logic rising-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `stb_i` in 1: upstream request strobe, held until `ack_o`.
- `we_i` in 1: upstream write enable.
- `sel_i` in 4: upstream byte lane select.
- `adr_i` in 30: upstream word address.
- `dat_i` in 32: upstream write data.
- `dat_o` out 32: upstream read data, registered; valid while `ack_o`=1 for a read.
- `ack_o` out 1: upstream acknowledge, one-cycle registered pulse.
- `mStb_o` out 1: downstream strobe to `mram` `stb_i`.
- `mWe_o` out 1: downstream write enable.
- `mSel_o` out 4: downstream byte select.
- `mAdr_o` out 30: downstream word address.
- `mDat_o` out 32: downstream write data.
- `mDat_i` in 32: downstream read data from `mram` `dat_o`.
- `mAck_i` in 1: downstream acknowledge from `mram` `ack_o`.
- `empty_o` out 1: 1 when FIFO is empty and no downstream write is in flight.

## Operation

- FIFO entry: {adr, sel, dat}, 66 bits. Registered read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH. Count of log2(DEPTH)+1 bits, range 0..DEPTH.
- Upstream sampling: a request is considered only when `stb_i`=1 and `ack_o`=0. The block never samples `stb_i` in a cycle where `ack_o`=1, which prevents a held strobe from being counted twice.
- Write (`we_i`=1), count<DEPTH: push the entry at the clock edge and set `ack_o`=1 in the next cycle.
- Write when full (count==DEPTH, using the registered count): no push and no ack. Retry every cycle. A pop in the same cycle does not unblock the push; the push happens on the following cycle.
- Write with `sel_i`=0000: acknowledged with normal timing, not enqueued.
- Read (`we_i`=0): held pending until the FIFO is empty and the drain FSM is in IDLE. Then issued downstream. When `mAck_i` arrives, `mDat_i` is registered into `dat_o` and `ack_o`=1 in the next cycle.
- Drain FSM states:
  - IDLE: all `m*` outputs hold their last values, with `mStb_o`=0. If count>0, go to WRITE. Otherwise, if an upstream read is pending, go to READ.
  - WRITE: `mStb_o`=1, `mWe_o`=1, `mAdr_o`/`mSel_o`/`mDat_o` = head entry, all stable. On `mAck_i`=1, pop the head and go to IDLE.
  - READ: `mStb_o`=1, `mWe_o`=0, `mAdr_o`=`adr_i`, `mSel_o`=`sel_i`. On `mAck_i`=1, capture data, pulse `ack_o`, go to IDLE.
- Writes have priority over reads. A pending read waits behind all posted writes, including writes pushed while the read is waiting.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- `mAck_i` is ignored in IDLE.
- `dat_o` holds its last value between reads.

## Timing

- Reset (asynchronous): `ack_o`=0, `dat_o`=0, `mStb_o`=0, `mWe_o`=0, `mSel_o`=0, `mAdr_o`=0, `mDat_o`=0, `empty_o`=1. Pointers and count are cleared and FSM returns to IDLE.
- Reset mid-operation discards all posted writes and any in-flight downstream access. `mStb_o` drops immediately.
- Write latency, not full: `stb_i` seen at edge N, `ack_o`=1 during cycle N+1, `ack_o`=0 at N+2.
- Downstream write start: entry pushed at edge N, `mStb_o`=1 from cycle N+2 (one cycle in IDLE first).
- `mStb_o` deasserts the cycle after `mAck_i` and stays low for at least one cycle between accesses.
- Read latency: `ack_o` = 1 cycle after `mAck_i`, with `dat_o` valid in that same cycle.
- `empty_o` is registered. It is 0 from the cycle after a push until the cycle after the last pop.

## Test plan

- Single write: stb/we/sel=1111/adr=0x10/dat=0xDEADBEEF. Required: `ack_o` 1 cycle later. `mStb_o` write with the same fields follows. Stub `mram` acks after 20 cycles, then `empty_o`=1.
- Burst of 6 writes, DEPTH=4, downstream ack latency 50 cycles. Required: first 4 acked back-to-back, 5th stalls until the first pop. Downstream order is adr 0..5 with matching data.
- Read-after-write: write 0x12345678 to adr 0x20, then immediately read adr 0x20. Required: the read is not issued downstream until the write is acked. `dat_o`=0x12345678 (stub memory).
- `sel_i`=0000 write: acked in 1 cycle. No downstream `mStb_o` and `empty_o` stays 1.
- Reset asserted while in WRITE with 3 entries queued. Required: `mStb_o`=0 immediately and `empty_o`=1. After release no stale writes appear downstream, and a new write works normally.
- Held strobe: master holds `stb_i` for 1 extra cycle after `ack_o`. Required: exactly one entry pushed.
